// File: rtl/dsp_mult_post_acc.sv
// dsp_mult_post_acc: accumulates DSP products over a frame, then rounds, shifts and saturates the sum
// onto a valid/ready result port with saturation flag and beat count.
module dsp_mult_post_acc #(
    parameter int ACC_W = 48,
    parameter int OUT_W = 20,
    parameter int SHIFT = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             lreset,
    input  logic [37:0]      z,
    input  logic             z_valid,
    input  logic             z_last,
    output logic             z_ready,
    input  logic             unsigned_z,
    output logic [OUT_W-1:0] res,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_sat,
    output logic [CNT_W-1:0] res_cnt
);
    // One guard bit above the accumulator so the rounding add cannot wrap.
    localparam int EW = ACC_W + 1;
    localparam logic [EW-1:0] RND = (EW'(1) << SHIFT) >> 1;
    localparam logic signed [EW-1:0] SMAX = (EW'(1) << (OUT_W - 1)) - EW'(1);
    localparam logic signed [EW-1:0] SMIN = -SMAX - EW'(1);
    localparam logic [EW-1:0] UMAX = (EW'(1) << OUT_W) - EW'(1);

    logic [ACC_W-1:0] acc_q, acc_d, z_ext, sum;
    logic             first_q, first_d, mode_q, mode_d, mode_eff;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_n, res_cnt_q, res_cnt_d;
    logic [OUT_W-1:0] res_q, res_d, fin;
    logic             res_valid_q, res_valid_d, res_sat_q, res_sat_d, fin_sat;
    logic [EW-1:0]    r_ext, r_sum, shu;
    logic signed [EW-1:0] shs;
    logic             hi_s, lo_s, hi_u, beat;

    assign z_ready   = !res_valid_q || res_ready;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign res_sat   = res_sat_q;
    assign res_cnt   = res_cnt_q;

    always_comb begin
        beat     = z_valid && z_ready;
        mode_eff = first_q ? unsigned_z : mode_q;
        z_ext    = mode_eff ? ACC_W'(z) : ACC_W'($signed(z));
        sum      = (first_q ? '0 : acc_q) + z_ext;
        cnt_n    = first_q ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1));
        r_ext    = mode_eff ? EW'(sum) : EW'($signed(sum));
        r_sum    = r_ext + RND;
        shs      = $signed(r_sum) >>> SHIFT;
        shu      = r_sum >> SHIFT;
        hi_s     = shs > SMAX;
        lo_s     = shs < SMIN;
        hi_u     = shu > UMAX;
        fin      = mode_eff ? (hi_u ? UMAX[OUT_W-1:0] : shu[OUT_W-1:0])
                            : (hi_s ? SMAX[OUT_W-1:0] : lo_s ? SMIN[OUT_W-1:0] : shs[OUT_W-1:0]);
        fin_sat  = mode_eff ? hi_u : (hi_s || lo_s);
        acc_d       = beat ? (z_last ? '0 : sum) : acc_q;
        cnt_d       = beat ? (z_last ? '0 : cnt_n) : cnt_q;
        first_d     = beat ? z_last : first_q;
        mode_d      = (beat && first_q) ? unsigned_z : mode_q;
        res_valid_d = (beat && z_last) ? 1'b1 : (res_valid_q && !res_ready ? 1'b1 : 1'b0);
        res_d       = (beat && z_last) ? fin : res_q;
        res_sat_d   = (beat && z_last) ? fin_sat : res_sat_q;
        res_cnt_d   = (beat && z_last) ? cnt_n : res_cnt_q;
    end

    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            mode_q      <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            res_sat_q   <= 1'b0;
            res_cnt_q   <= '0;
        end else begin
            acc_q       <= acc_d;
            first_q     <= first_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            res_sat_q   <= res_sat_d;
            res_cnt_q   <= res_cnt_d;
        end
    end
endmodule

// File: tb/tb_dsp_mult_post_acc.sv
// tb_dsp_mult_post_acc: directed vectors with hand-computed results for dsp_mult_post_acc.
module tb_dsp_mult_post_acc;
    logic        clk = 0;
    logic        lreset = 0;
    logic [37:0] z = '0;
    logic        z_valid = 0, z_last = 0, unsigned_z = 0, res_ready = 1;
    logic        z_ready, res_valid, res_sat;
    logic [19:0] res;
    logic [7:0]  res_cnt;
    int          n_run = 0, n_fail = 0;

    dsp_mult_post_acc dut (
        .clk(clk), .lreset(lreset), .z(z), .z_valid(z_valid), .z_last(z_last),
        .z_ready(z_ready), .unsigned_z(unsigned_z), .res(res), .res_valid(res_valid),
        .res_ready(res_ready), .res_sat(res_sat), .res_cnt(res_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [37:0] zv, input logic last, input logic uns);
        z = zv;
        z_last = last;
        unsigned_z = uns;
        z_valid = 1;
        @(posedge clk);
        #1;
        z_valid = 0;
        z_last = 0;
    endtask

    task automatic idle();
        z_valid = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_res(input string tag, input logic [19:0] r, input logic s, input logic [7:0] c);
        chk({tag, ".valid"}, 64'(res_valid), 64'd1);
        chk({tag, ".res"}, 64'(res), 64'(r));
        chk({tag, ".sat"}, 64'(res_sat), 64'(s));
        chk({tag, ".cnt"}, 64'(res_cnt), 64'(c));
    endtask

    initial begin
        #12;
        chk("rst.res", 64'(res), 64'd0);
        chk("rst.valid", 64'(res_valid), 64'd0);
        chk("rst.cnt", 64'(res_cnt), 64'd0);
        chk("rst.zready", 64'(z_ready), 64'd1);
        @(posedge clk);
        #1 lreset = 1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(38'd256, i == 3, 0);
        chk_res("sum4", 20'd4, 0, 8'd4);
        idle();
        chk("sum4.pulse", 64'(res_valid), 64'd0);

        send(38'h3F_FFFF_FE80, 1, 0);
        chk_res("neg1", 20'hFFFFF, 0, 8'd1);
        chk("b2b.zready0", 64'(z_ready), 64'd1);
        send(38'd512, 1, 0);
        chk_res("b2b.a", 20'd2, 0, 8'd1);
        chk("b2b.zready1", 64'(z_ready), 64'd1);
        send(38'd768, 1, 0);
        chk_res("b2b.b", 20'd3, 0, 8'd1);
        idle();

        send(38'h1F_FFFF_FFFF, 0, 0);
        send(38'h1F_FFFF_FFFF, 1, 0);
        chk_res("satp", 20'h7FFFF, 1, 8'd2);
        send(38'h20_0000_0000, 0, 0);
        send(38'h20_0000_0000, 1, 0);
        chk_res("satn", 20'h80000, 1, 8'd2);
        send(38'h3F_FFFF_FFFF, 1, 1);
        chk_res("satu", 20'hFFFFF, 1, 8'd1);
        idle();

        res_ready = 0;
        for (int i = 0; i < 4; i++) send(38'd256, i == 3, 0);
        chk_res("bp.first", 20'd4, 0, 8'd4);
        z = 38'd512;
        z_last = 0;
        unsigned_z = 0;
        z_valid = 1;
        #1 chk("bp.zready", 64'(z_ready), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 chk("bp.hold", 64'({res_valid, res}), 64'({1'b1, 20'd4}));
        end
        res_ready = 1;
        #1 chk("bp.release", 64'(z_ready), 64'd1);
        @(posedge clk);
        #1;
        send(38'd768, 1, 0);
        chk_res("bp.next", 20'd5, 0, 8'd2);
        idle();

        send(38'h20_0000_0000, 0, 1);
        send(38'h20_0000_0000, 1, 0);
        chk_res("mode", 20'hFFFFF, 1, 8'd2);

        send(38'd1000, 0, 0);
        send(38'd1000, 0, 0);
        lreset = 0;
        #1;
        chk("arst.res", 64'(res), 64'd0);
        chk("arst.sat", 64'(res_sat), 64'd0);
        chk("arst.valid", 64'(res_valid), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 lreset = 1;
        @(posedge clk);
        #1;
        send(38'd512, 1, 0);
        chk_res("arst.after", 20'd2, 0, 8'd1);

        z = 38'd4096;
        z_last = 1;
        z_valid = 0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 chk("lastnovalid", 64'(res_valid), 64'd0);
        z_last = 0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
